// File: rtl/hack_keyboard.sv
// hack_keyboard: PS/2 set-2 receiver and scan-code translator driving the Hack keyboard word.
module hack_keyboard #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [1:0] clk_s, data_s;
    logic [FW-1:0] fcnt;
    logic filt, filt_d, strobe, din, timeout, accept, err;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] shift, shift_n, code;
    logic par, par_n, ext, brk;
    logic [TW-1:0] tcnt;
    assign din = data_s[1];
    assign strobe = filt_d & ~filt;
    assign timeout = (state != IDLE) && !strobe && (tcnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s  <= 2'b11;
            data_s <= 2'b11;
            fcnt   <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk};
            data_s <= {data_s[0], ps2_data};
            filt_d <= filt;
            if (clk_s[1] == filt) fcnt <= '0;
            else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s[1];
                fcnt <= '0;
            end else fcnt <= fcnt + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        shift_n = shift;
        par_n   = par;
        accept  = 1'b0;
        err     = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE: begin
                    state_n = din ? IDLE : DATA;
                    bcnt_n  = 3'd0;
                    err     = din;
                end
                DATA: begin
                    shift_n = {din, shift[7:1]};
                    bcnt_n  = bcnt + 3'd1;
                    state_n = (bcnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = din;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    accept  = din & (^{shift, par});
                    err     = ~accept;
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            shift      <= shift_n;
            par        <= par_n;
            tcnt       <= (state == IDLE || strobe) ? '0 : tcnt + 1'b1;
            byte_valid <= accept;
            frame_err  <= err;
            if (accept) byte_data <= shift;
        end
    end
    // Upper bit selects the E0-extended table.
    always_comb begin
        code = 8'd0;
        case ({ext, byte_data})
            9'h01C: code = 8'd65;  9'h032: code = 8'd66;  9'h021: code = 8'd67;  9'h023: code = 8'd68;
            9'h024: code = 8'd69;  9'h02B: code = 8'd70;  9'h034: code = 8'd71;  9'h033: code = 8'd72;
            9'h043: code = 8'd73;  9'h03B: code = 8'd74;  9'h042: code = 8'd75;  9'h04B: code = 8'd76;
            9'h03A: code = 8'd77;  9'h031: code = 8'd78;  9'h044: code = 8'd79;  9'h04D: code = 8'd80;
            9'h015: code = 8'd81;  9'h02D: code = 8'd82;  9'h01B: code = 8'd83;  9'h02C: code = 8'd84;
            9'h03C: code = 8'd85;  9'h02A: code = 8'd86;  9'h01D: code = 8'd87;  9'h022: code = 8'd88;
            9'h035: code = 8'd89;  9'h01A: code = 8'd90;
            9'h045: code = 8'd48;  9'h016: code = 8'd49;  9'h01E: code = 8'd50;  9'h026: code = 8'd51;
            9'h025: code = 8'd52;  9'h02E: code = 8'd53;  9'h036: code = 8'd54;  9'h03D: code = 8'd55;
            9'h03E: code = 8'd56;  9'h046: code = 8'd57;
            9'h00E: code = 8'd96;  9'h04E: code = 8'd45;  9'h055: code = 8'd61;  9'h054: code = 8'd91;
            9'h05B: code = 8'd93;  9'h05D: code = 8'd92;  9'h04C: code = 8'd59;  9'h052: code = 8'd39;
            9'h041: code = 8'd44;  9'h049: code = 8'd46;  9'h04A: code = 8'd47;
            9'h029: code = 8'd32;  9'h05A: code = 8'd128; 9'h066: code = 8'd129; 9'h076: code = 8'd140;
            9'h005: code = 8'd141; 9'h006: code = 8'd142; 9'h004: code = 8'd143; 9'h00C: code = 8'd144;
            9'h003: code = 8'd145; 9'h00B: code = 8'd146; 9'h083: code = 8'd147; 9'h00A: code = 8'd148;
            9'h001: code = 8'd149; 9'h009: code = 8'd150; 9'h078: code = 8'd151; 9'h007: code = 8'd152;
            9'h16B: code = 8'd130; 9'h175: code = 8'd131; 9'h174: code = 8'd132; 9'h172: code = 8'd133;
            9'h16C: code = 8'd134; 9'h169: code = 8'd135; 9'h17D: code = 8'd136; 9'h17A: code = 8'd137;
            9'h170: code = 8'd138; 9'h171: code = 8'd139; 9'h15A: code = 8'd128;
            default: code = 8'd0;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out <= '0;
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == 8'hE0) ext <= 1'b1;
            else if (byte_data == 8'hF0) brk <= 1'b1;
            else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (code != 8'd0 && !brk) out <= {8'd0, code};
                else if (code != 8'd0 && {8'd0, code} == out) out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hack_keyboard.sv
// tb_hack_keyboard: drives PS/2 frames into hack_keyboard and checks bytes, errors and the keyboard word.
module tb_hack_keyboard;
    localparam int FL = 4, TO = 200, HP = 16;
    logic clock = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [15:0] out;
    logic byte_valid, frame_err;
    logic [7:0] byte_data;
    int tests = 0, fails = 0;
    int errs = 0, stray = 0;
    logic prev_bv = 1'b0;
    logic [15:0] last_out = 16'd0;
    logic [7:0] bv_q[$];
    logic [15:0] out_q[$];
    int tmap[int];
    int keys[$];
    bit m_ext = 0, m_brk = 0;
    logic [15:0] m_out = 16'd0;
    logic [7:0] lsc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
                           8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dsc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] psc[11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    int pch[11] = '{96, 45, 61, 91, 93, 92, 59, 39, 44, 46, 47};
    logic [7:0] fsc[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    logic [7:0] esc[10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

    hack_keyboard #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out(out), .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (prev_bv) out_q.push_back(out);
        else if (reset && out !== last_out) stray <= stray + 1;
        prev_bv  <= byte_valid;
        last_out <= out;
        if (byte_valid === 1'b1) bv_q.push_back(byte_data);
        if (frame_err === 1'b1) errs <= errs + 1;
    end

    function automatic void add(input int e, input logic [7:0] sc, input int c);
        tmap[e * 256 + int'(sc)] = c;
        keys.push_back(e * 256 + int'(sc));
    endfunction

    function automatic void init_map();
        string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        string digits = "0123456789";
        foreach (lsc[i]) add(0, lsc[i], int'(letters[i]));
        foreach (dsc[i]) add(0, dsc[i], int'(digits[i]));
        foreach (psc[i]) add(0, psc[i], pch[i]);
        foreach (fsc[i]) add(0, fsc[i], 141 + i);
        foreach (esc[i]) add(1, esc[i], 130 + i);
        add(0, 8'h29, 32);
        add(0, 8'h5A, 128);
        add(0, 8'h66, 129);
        add(0, 8'h76, 140);
        add(1, 8'h5A, 128);
    endfunction

    function automatic void model(input logic [7:0] b);
        int k, c;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            c = tmap.exists(k) ? tmap[k] : 0;
            if (c != 0 && !m_brk) m_out = 16'(c);
            else if (c != 0 && int'(m_out) == c) m_out = 16'd0;
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit flip_par = 0, input bit bad_stop = 0,
                              input int nbits = 11, input bit glitch = 0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HP / 2) @(posedge clock);
            if (glitch) begin
                ps2_clk = 1'b0;
                repeat (2) @(posedge clock);
                ps2_clk = 1'b1;
            end
            repeat (HP / 2) @(posedge clock);
            ps2_clk = 1'b0;
            repeat (HP) @(posedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HP) @(posedge clock);
    endtask

    task automatic send_check(input logic [7:0] b, input bit glitch = 0);
        int e0;
        bv_q.delete();
        out_q.delete();
        e0 = errs;
        send_frame(b, 0, 0, 11, glitch);
        model(b);
        @(negedge clock);
        tests++;
        if (bv_q.size() != 1 || bv_q[0] !== b) begin
            fails++;
            $display("FAIL byte_%h: got %0d pulses, first %h; want 1 pulse of %h", b, bv_q.size(),
                     (bv_q.size() > 0) ? bv_q[0] : 8'hxx, b);
        end
        tests++;
        if (out_q.size() != 1 || out_q[0] !== m_out) begin
            fails++;
            $display("FAIL out_latency_%h: got %h one cycle after byte_valid, want %h", b,
                     (out_q.size() > 0) ? out_q[0] : 16'hxxxx, m_out);
        end
        tests++;
        if (out !== m_out) begin
            fails++;
            $display("FAIL out_%h: got %h want %h", b, out, m_out);
        end
        tests++;
        if (errs != e0) begin
            fails++;
            $display("FAIL noerr_%h: got %0d frame_err pulses want 0", b, errs - e0);
        end
    endtask

    task automatic send_bad(input logic [7:0] b, input bit flip_par, input bit bad_stop, input string nm);
        int e0;
        bv_q.delete();
        e0 = errs;
        send_frame(b, flip_par, bad_stop);
        @(negedge clock);
        tests++;
        if (errs - e0 != 1 || bv_q.size() != 0 || out !== m_out) begin
            fails++;
            $display("FAIL %s: got err=%0d valid=%0d out=%h want err=1 valid=0 out=%h", nm, errs - e0,
                     bv_q.size(), out, m_out);
        end
    endtask

    task automatic test_reset();
        int e0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        tests++;
        if ({out, byte_valid, frame_err, byte_data} !== 26'd0) begin
            fails++;
            $display("FAIL reset_state: got out=%h bv=%b err=%b data=%h want all 0", out, byte_valid, frame_err, byte_data);
        end
        e0 = errs;
        bv_q.delete();
        reset = 1'b1;
        repeat (30) @(posedge clock);
        @(negedge clock);
        tests++;
        if (errs != e0 || bv_q.size() != 0 || out !== 16'd0) begin
            fail_idle(errs - e0);
        end
    endtask

    task automatic fail_idle(input int n);
        fails++;
        $display("FAIL idle_after_reset: got err=%0d valid=%0d out=%h want 0 0 0000", n, bv_q.size(), out);
    endtask

    task automatic test_make_break();
        send_check(8'h1C);
        send_check(8'hF0);
        send_check(8'h1C);
        send_check(8'h1C);
        send_check(8'h32);
        send_check(8'hF0);
        send_check(8'h1C);
        send_check(8'hF0);
        send_check(8'h32);
    endtask

    task automatic test_extended();
        send_check(8'hE0); send_check(8'h75);
        send_check(8'hE0); send_check(8'hF0); send_check(8'h75);
        send_check(8'hE0); send_check(8'h5A);
        send_check(8'hF0); send_check(8'hE0); send_check(8'h5A);
        send_check(8'hE0); send_check(8'hE0); send_check(8'h6B);
        send_check(8'hF0); send_check(8'hF0); send_check(8'hE0); send_check(8'h6B);
        send_check(8'h07);
        send_check(8'h41);
    endtask

    task automatic test_frame_errors();
        send_check(8'h1C);
        send_bad(8'h1C, 1, 0, "parity_err");
        send_bad(8'h1C, 0, 1, "stop_err");
        send_check(8'hE0);
        send_bad(8'h32, 1, 0, "parity_err_keeps_ext");
        send_check(8'h75);
        send_check(8'hE0); send_check(8'hF0); send_check(8'h75);
    endtask

    task automatic test_timeout();
        int e0;
        bv_q.delete();
        e0 = errs;
        send_frame(8'h55, 0, 0, 5);
        repeat (TO + 50) @(posedge clock);
        @(negedge clock);
        tests++;
        if (errs - e0 != 1 || bv_q.size() != 0) begin
            fails++;
            $display("FAIL timeout: got err=%0d valid=%0d want err=1 valid=0", errs - e0, bv_q.size());
        end
        send_check(8'h16);
    endtask

    task automatic test_glitch();
        int e0;
        bv_q.delete();
        e0 = errs;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge clock);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clock);
        end
        @(negedge clock);
        tests++;
        if (errs != e0 || bv_q.size() != 0) begin
            fails++;
            $display("FAIL glitch_idle: got err=%0d valid=%0d want 0 0", errs - e0, bv_q.size());
        end
        send_check(8'h4D, 1);
        send_check(8'hF0, 1);
        send_check(8'h4D, 1);
    endtask

    task automatic test_reset_mid();
        int e0;
        send_check(8'h32);
        send_check(8'hF0);
        send_frame(8'h1C, 0, 0, 4);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests++;
        if (out !== 16'd0 || byte_valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got out=%h bv=%b err=%b want 0000 0 0", out, byte_valid, frame_err);
        end
        m_out = 16'd0;
        m_ext = 0;
        m_brk = 0;
        reset = 1'b1;
        e0 = errs;
        repeat (TO + 20) @(posedge clock);
        @(negedge clock);
        tests++;
        if (errs != e0) begin
            fails++;
            $display("FAIL reset_mid_idle: got %0d frame_err pulses want 0", errs - e0);
        end
        send_check(8'h1C);
    endtask

    task automatic test_random();
        int r, k;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) send_check(8'hE0);
            else if (r == 1) send_check(8'hF0);
            else if (r == 2) send_check(8'($urandom_range(0, 255)));
            else begin
                k = keys[$urandom_range(0, keys.size() - 1)];
                if (r == 3) send_check(8'hF0);
                if (k >= 256) send_check(8'hE0);
                send_check(8'(k));
            end
        end
    endtask

    task automatic test_out_stable();
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL out_stable: got %0d unexpected out changes want 0", stray);
        end
    endtask

    initial begin
        init_map();
        test_reset();
        test_make_break();
        test_extended();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        test_out_stable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hack_keyboard.md
Name: hack_keyboard

Overview:
- PS/2 keyboard receiver and scan-code translator. It drives the 16-bit memory-mapped keyboard word at address 0x6000 in the Hack Memory block, replacing the constant keyboard register.
- Receives PS/2 set-2 frames, decodes make, break and E0-extended sequences, and holds the Hack key code of the key currently pressed. Holds 0 when no mapped key is down.
- The Memory read mux consumes out directly. There is no write path.

Parameters:
- FILTER_LEN, 4, number of consecutive equal synchronised samples required before the ps2_clk level is accepted.
- TIMEOUT, 10000, idle clock cycles between ps2_clk falling edges that abort a partial frame.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clock.
- ps2_data  in  1  raw PS/2 data, asynchronous to clock.
- out  out  16  Hack key code (keyboard word); 0 means no key pressed.
- byte_valid  out  1  one-cycle pulse when a frame is accepted.
- byte_data  out  8  last accepted scan-code byte; valid while byte_valid is high, held otherwise.
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (reset=0): out=0, byte_data=0, byte_valid=0, frame_err=0. The receiver FSM goes to IDLE; prefix flags, timeout counter and filter are cleared. Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
- Filter: the filtered ps2_clk changes level only after FILTER_LEN equal synced samples.
- A falling edge of the filtered clock is a bit strobe. ps2_data (synced) is sampled in that same cycle.
- Receiver FSM:
  - IDLE: on a strobe, if data=0 go to DATA with bit count 0; if data=1, pulse frame_err and stay in IDLE.
  - DATA: shift the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: store the bit. Go to STOP.
  - STOP: the frame is accepted when stop=1 and the 9 bits (data plus parity) have odd parity. On accept, go to IDLE, load byte_data and pulse byte_valid in the next cycle. Otherwise go to IDLE and pulse frame_err.
- Timeout: in any state other than IDLE, a counter increments each clock and resets on every strobe. When it reaches TIMEOUT, go to IDLE and pulse frame_err. Bytes in error never reach the decoder.
- Decoder, acting on each accepted byte:
  - 0xE0 sets ext=1.
  - 0xF0 sets brk=1.
  - Any other byte b forms code = translate(ext, b), then clears ext and brk.
  - Make (brk=0) with code≠0: out←code. A new make overrides the previously held key; typematic repeats rewrite the same value.
  - Break (brk=1): out←0 only if code==out. Otherwise out is unchanged.
  - code==0 (unmapped key): out is unchanged.
- out changes exactly 1 cycle after the byte_valid pulse of the final byte of a sequence.
- translate(ext=0):
  - Letters map to uppercase ASCII. Examples: 1C→65 'A', 32→66 'B', 1A→90 'Z'.
  - Digits: 45→48 '0', 16→49 '1'.
  - 29→32 space, 5A→128 newline, 66→129 backspace, 76→140 escape.
  - F1–F12 (05,06,04,0C,03,0B,83,0A,01,09,78,07) map to 141–152.
  - Printable punctuation maps to unshifted ASCII. Example: 41→44 ','.
  - Everything else maps to 0. No shift or caps handling.
- translate(ext=1):
  - 6B→130 left, 75→131 up, 74→132 right, 72→133 down.
  - 6C→134 home, 69→135 end, 7D→136 page up, 7A→137 page down.
  - 70→138 insert, 71→139 delete, 5A→128 (keypad enter).
  - Everything else maps to 0.
- Edge cases:
  - E0 F0 xx and F0 E0 xx are both an extended break.
  - Repeated E0 or F0 bytes are idempotent.
  - A frame error does not clear ext or brk.
- The translate table is a combinational case statement; all other state is registered.

Test Plan:
- Reset held low, then released with ps2 lines idle high → out=0x0000, no pulses; assert reset mid-DATA → FSM in IDLE, out=0; next full frame for 0x1C decodes normally.
- Send frame 0x1C (parity 0, stop 1) → byte_valid pulse with byte_data=0x1C, out=0x0041 one cycle later; then F0,1C → out=0x0000.
- Send 1C, then 32, then F0 1C → out: 0x0041, 0x0042, stays 0x0042; then F0 32 → 0x0000.
- Send E0 75 → out=0x0083 (131); E0 F0 75 → 0x0000; E0 5A → 0x0080.
- Frame 0x1C with wrong parity bit → frame_err pulse, no byte_valid, out unchanged; frame with stop=0 → same.
- Send 5 bits of a frame, then idle for TIMEOUT cycles → frame_err pulse; next valid frame 0x16 → out=0x0031; glitch pulses on ps2_clk shorter than FILTER_LEN cycles → no strobe, no bit shifted.
